// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external ALU.
// One operation in flight; the result is held until its owner takes it.
module alu_arbiter #(
   parameter int PRIO_INIT = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [2:0] req0_op,
   input  logic [3:0] req0_a,
   input  logic [3:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [2:0] req1_op,
   input  logic [3:0] req1_a,
   input  logic [3:0] req1_b,
   output logic       rsp0_valid,
   input  logic       rsp0_ready,
   output logic       rsp1_valid,
   input  logic       rsp1_ready,
   output logic [3:0] rsp_data,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_s,
   input  logic [3:0] alu_o,
   output logic       busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   // last_q holds the most recent grant, so its reset value is the loser
   localparam logic LAST_RST = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

   state_t     state_q, state_d;
   logic       last_q, last_d;
   logic       owner_q, owner_d;
   logic       rsp0_valid_q, rsp0_valid_d;
   logic       rsp1_valid_q, rsp1_valid_d;
   logic [3:0] rsp_data_q, rsp_data_d;
   logic [3:0] alu_a_q, alu_a_d;
   logic [3:0] alu_b_q, alu_b_d;
   logic [2:0] alu_s_q, alu_s_d;
   logic       gnt0, gnt1;
   logic       owner_rdy;

   always_comb begin
      gnt0 = req0_valid && (!req1_valid || last_q);
      gnt1 = req1_valid && (!req0_valid || !last_q);
      req0_ready = (state_q == IDLE) && gnt0;
      req1_ready = (state_q == IDLE) && gnt1;
      owner_rdy = owner_q ? rsp1_ready : rsp0_ready;

      state_d      = state_q;
      last_d       = last_q;
      owner_d      = owner_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp_data_d   = rsp_data_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_s_d      = alu_s_q;

      case (state_q)
         IDLE: begin
            if (gnt0) begin
               alu_a_d = req0_a;
               alu_b_d = req0_b;
               alu_s_d = req0_op;
               owner_d = 1'b0;
               last_d  = 1'b0;
               state_d = EXEC;
            end else if (gnt1) begin
               alu_a_d = req1_a;
               alu_b_d = req1_b;
               alu_s_d = req1_op;
               owner_d = 1'b1;
               last_d  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d   = alu_o;
            rsp0_valid_d = !owner_q;
            rsp1_valid_d = owner_q;
            state_d      = RESP;
         end
         RESP: begin
            if (owner_rdy) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: begin
            rsp0_valid_d = 1'b0;
            rsp1_valid_d = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_q       <= LAST_RST;
         owner_q      <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp_data_q   <= 4'd0;
         alu_a_q      <= 4'd0;
         alu_b_q      <= 4'd0;
         alu_s_q      <= 3'd0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         owner_q      <= owner_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp_data_q   <= rsp_data_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_s_q      <= alu_s_d;
      end
   end

   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp_data   = rsp_data_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_s      = alu_s_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios, then random traffic
// against a transaction-level timeline model with an external ALU model.
module tb_alu_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_ready;
   logic [2:0] req0_op;
   logic [3:0] req0_a, req0_b;
   logic       req1_valid, req1_ready;
   logic [2:0] req1_op;
   logic [3:0] req1_a, req1_b;
   logic       rsp0_valid, rsp0_ready;
   logic       rsp1_valid, rsp1_ready;
   logic [3:0] rsp_data;
   logic [3:0] alu_a, alu_b;
   logic [2:0] alu_s;
   logic [3:0] alu_o;
   logic       busy;

   int checks = 0;
   int failures = 0;

   alu_arbiter #(.PRIO_INIT(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
      .alu_o(alu_o), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] alu_f(input logic [2:0] s,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
      int r;
      if (s[2]) r = (a < b) ? a : b;
      else if (s[1:0] == 2'd0) r = a | b;
      else if (s[1:0] == 2'd1) r = a & b;
      else if (s[1:0] == 2'd2) r = (a + b) % 16;
      else r = (a - b + 16) % 16;
      return 4'(r);
   endfunction

   always_comb alu_o = alu_f(alu_s, alu_a, alu_b);

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   // random-phase model state
   logic       v [2];
   logic [2:0] mop [2];
   logic [3:0] ma [2];
   logic [3:0] mb [2];
   logic       rr [2];
   logic       pend, own, last, w;
   int         age;
   logic [3:0] expd, xa, xb;
   logic [2:0] xs;

   initial begin
      rst_n = 1'b0;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      cyc(); #1;
      chk("rst_busy", busy, 0);
      chk("rst_rsp0v", rsp0_valid, 0);
      chk("rst_rsp1v", rsp1_valid, 0);
      chk("rst_data", rsp_data, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_alu_b", alu_b, 0);
      chk("rst_alu_s", alu_s, 0);

      // single req0 ADD 9+8 wraps to 1
      rst_n = 1'b1;
      req0_valid = 1; req0_op = 3'b010; req0_a = 9; req0_b = 8;
      #1;
      chk("add_rdy0", req0_ready, 1);
      chk("add_rdy1", req1_ready, 0);
      cyc(); req0_valid = 0; #1;
      chk("add_busy", busy, 1);
      chk("add_alu_a", alu_a, 9);
      chk("add_alu_b", alu_b, 8);
      chk("add_alu_s", alu_s, 2);
      chk("add_exec_rsp0v", rsp0_valid, 0);
      cyc(); #1;
      chk("add_rsp0v", rsp0_valid, 1);
      chk("add_data", rsp_data, 1);
      chk("add_rsp1v", rsp1_valid, 0);
      rsp0_ready = 1;
      cyc(); rsp0_ready = 0; #1;
      chk("add_done_v", rsp0_valid, 0);
      chk("add_done_busy", busy, 0);

      // contention after reset: req0 first, then req1
      do_reset();
      req0_valid = 1; req0_op = 3'b000; req0_a = 5; req0_b = 10;
      req1_valid = 1; req1_op = 3'b011; req1_a = 3; req1_b = 5;
      #1;
      chk("rr_rdy0", req0_ready, 1);
      chk("rr_rdy1", req1_ready, 0);
      cyc(); req0_valid = 0; #1;
      chk("rr_exec_rdy1", req1_ready, 0);
      cyc(); #1;
      chk("rr_or_v", rsp0_valid, 1);
      chk("rr_or_data", rsp_data, 15);
      rsp0_ready = 1;
      cyc(); rsp0_ready = 0; #1;
      chk("rr_idle_rdy1", req1_ready, 1);
      cyc(); req1_valid = 0;
      cyc(); #1;
      chk("rr_sub_v", rsp1_valid, 1);
      chk("rr_sub_data", rsp_data, 14);
      chk("rr_sub_v0", rsp0_valid, 0);
      rsp1_ready = 1;
      cyc(); rsp1_ready = 0;

      // grants alternate while both stay valid
      req0_valid = 1; req1_valid = 1;
      rsp0_ready = 1; rsp1_ready = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("alt_rdy0", req0_ready, (k % 2 == 0));
         chk("alt_rdy1", req1_ready, (k % 2 == 1));
         cyc(); cyc(); cyc();
      end
      req0_valid = 0; req1_valid = 0;
      rsp0_ready = 0; rsp1_ready = 0;

      // req1 MIN with a held-off response
      req1_valid = 1; req1_op = 3'b100; req1_a = 12; req1_b = 7;
      #1;
      chk("min_rdy1", req1_ready, 1);
      cyc(); req1_valid = 0;
      cyc(); #1;
      chk("min_v", rsp1_valid, 1);
      chk("min_data", rsp_data, 7);
      req0_valid = 1; rsp0_ready = 1;
      for (int k = 0; k < 5; k++) begin
         cyc(); #1;
         chk("hold_v1", rsp1_valid, 1);
         chk("hold_v0", rsp0_valid, 0);
         chk("hold_data", rsp_data, 7);
         chk("hold_rdy0", req0_ready, 0);
         chk("hold_rdy1", req1_ready, 0);
      end
      req0_valid = 0; rsp0_ready = 0; rsp1_ready = 1;
      cyc(); rsp1_ready = 0; #1;
      chk("min_done_busy", busy, 0);
      chk("min_done_v", rsp1_valid, 0);

      // reset in EXEC abandons the operation
      req0_valid = 1; req0_op = 3'b010; req0_a = 3; req0_b = 4;
      cyc(); req0_valid = 0; #1;
      chk("abort_busy_pre", busy, 1);
      rst_n = 0; #1;
      chk("abort_busy", busy, 0);
      chk("abort_v0", rsp0_valid, 0);
      chk("abort_v1", rsp1_valid, 0);
      chk("abort_data", rsp_data, 0);
      chk("abort_alu_a", alu_a, 0);
      chk("abort_alu_b", alu_b, 0);
      chk("abort_alu_s", alu_s, 0);
      cyc(); cyc(); #1;
      chk("abort_v0_late", rsp0_valid, 0);
      rst_n = 1;
      req0_valid = 1; req0_op = 3'b001; req0_a = 12; req0_b = 10;
      #1;
      chk("and_rdy0", req0_ready, 1);
      cyc(); req0_valid = 0;
      cyc(); #1;
      chk("and_v", rsp0_valid, 1);
      chk("and_data", rsp_data, 8);
      rsp0_ready = 1;
      cyc();

      // back-to-back req0 with ready tied high
      req0_valid = 1; req0_op = 3'b010; req0_a = 1; req0_b = 2;
      for (int c = 0; c < 9; c++) begin
         #1;
         chk("b2b_rdy0", req0_ready, (c % 3 == 0));
         chk("b2b_busy", busy, (c % 3 != 0));
         cyc();
      end
      req0_valid = 0; rsp0_ready = 0;
      cyc();

      // random traffic against the timeline model
      do_reset();
      pend = 0; own = 0; last = 1; age = 0;
      xa = 0; xb = 0; xs = 0; expd = 0;
      for (int n = 0; n < 2; n++) begin
         v[n] = 0; mop[n] = 0; ma[n] = 0; mb[n] = 0; rr[n] = 0;
      end
      for (int i = 0; i < 400; i++) begin
         for (int n = 0; n < 2; n++) begin
            if (!v[n] && $urandom_range(0, 2) == 0) begin
               v[n]   = 1;
               mop[n] = 3'($urandom_range(0, 7));
               ma[n]  = 4'($urandom_range(0, 15));
               mb[n]  = 4'($urandom_range(0, 15));
            end
            rr[n] = ($urandom_range(0, 2) != 0);
         end
         req0_valid = v[0]; req0_op = mop[0]; req0_a = ma[0]; req0_b = mb[0];
         req1_valid = v[1]; req1_op = mop[1]; req1_a = ma[1]; req1_b = mb[1];
         rsp0_ready = rr[0]; rsp1_ready = rr[1];
         #1;
         w = (v[0] && v[1]) ? !last : !v[0];
         chk("rnd_busy", busy, pend);
         chk("rnd_rdy0", req0_ready, !pend && v[0] && w == 0);
         chk("rnd_rdy1", req1_ready, !pend && v[1] && w == 1);
         chk("rnd_v0", rsp0_valid, pend && age >= 2 && own == 0);
         chk("rnd_v1", rsp1_valid, pend && age >= 2 && own == 1);
         if (pend && age >= 2) chk("rnd_data", rsp_data, expd);
         chk("rnd_alu_a", alu_a, xa);
         chk("rnd_alu_b", alu_b, xb);
         chk("rnd_alu_s", alu_s, xs);
         if (!pend && (v[0] || v[1])) begin
            pend = 1; age = 1; own = w; last = w;
            xa = ma[w]; xb = mb[w]; xs = mop[w];
            expd = alu_f(mop[w], ma[w], mb[w]);
            v[w] = 0;
         end else if (pend) begin
            if (age >= 2 && rr[own]) pend = 0;
            else age++;
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, index of the requester given priority first after reset (0 or 1).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  block accepts requester N's operation this cycle.
REQ-006 reqN_op  input  3  operation code: 000 OR, 001 AND, 010 ADD, 011 SUB, 1xx MIN.
REQ-007 reqN_a, reqN_b  input  4 each  operands.
REQ-008 rspN_valid  output  1  result for requester N is available on rsp_data.
REQ-009 rspN_ready  input  1  requester N takes the result.
REQ-010 rsp_data  output  4  registered result, shared by both response channels.
REQ-011 alu_a, alu_b  output  4 each  registered operands driven to the shared ALU.
REQ-012 alu_s  output  3  registered operation select driven to the shared ALU.
REQ-013 alu_o  input  4  combinational ALU result, 4-bit wrapping arithmetic.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, EXEC and RESP.
REQ-016 In IDLE, grant SHALL go to the single valid requester; if both are valid, it SHALL go to the requester not granted most recently (round-robin pointer).
REQ-017 reqN_ready SHALL be combinational, high only in IDLE and only for the granted requester; both ready outputs SHALL be low in EXEC and RESP.
REQ-018 An accept occurs at an edge where reqN_valid and reqN_ready are both high; on that edge alu_a, alu_b and alu_s SHALL load reqN_a, reqN_b and reqN_op unmodified, the owner index SHALL be latched, the pointer SHALL be set to N, and the state SHALL move to EXEC.
REQ-019 At the edge leaving EXEC, rsp_data SHALL load alu_o, rsp<owner>_valid SHALL be set, and the state SHALL move to RESP.
REQ-020 In RESP, rsp_data and rsp<owner>_valid SHALL hold until rsp<owner>_ready is high at an edge; at that edge valid SHALL clear and the state SHALL return to IDLE.
REQ-021 The non-owner's rsp valid SHALL remain 0 at all times; the non-owner's rspN_ready SHALL be ignored.
REQ-022 Latency: response valid SHALL appear 2 edges after accept; minimum spacing between accepts SHALL be 3 cycles.
REQ-023 alu_a, alu_b and alu_s SHALL hold their last values outside EXEC (no toggling while idle).
REQ-024 A request arriving or dropping during EXEC or RESP SHALL not affect the operation in flight; reqN_valid is required to hold until accepted (protocol rule, not checked).
REQ-025 The block SHALL use exactly one ALU operation per accept, with no queuing; the pointer changes only on an accept.
REQ-026 Arithmetic is performed by the external ALU; the block SHALL not alter widths or values, so a 4-bit wrap such as 9+8=1 passes through as-is.

Reset
REQ-027 While rst_n is low: state IDLE, all rsp valids 0, rsp_data 0, alu_a/alu_b/alu_s 0, busy 0, and the pointer set so that PRIO_INIT wins the first contention.
REQ-028 Reset asserted mid-operation SHALL abandon the operation with no response issued; after release, the block SHALL accept a new request on the first edge.

Verification
REQ-029 Req0 only, op=010, a=9, b=8 -> accepted in IDLE; rsp0_valid high 2 edges later with rsp_data=1; rsp1_valid stays 0.
REQ-030 Both valid after reset, PRIO_INIT=0: req0 OR 5|10, req1 SUB 3-5 -> req0 served first with rsp_data=15, then req1 with rsp_data=14; grants alternate while both stay valid.
REQ-031 Req1 op=100, a=12, b=7 -> rsp_data=7; with rsp1_ready held low for 5 cycles, valid and data hold and both ready outputs stay low; first ready edge returns the FSM to IDLE.
REQ-032 rst_n pulsed low during EXEC -> no rsp valid; all outputs at reset values; a subsequent req0 AND 12&10 -> rsp_data=8.
REQ-033 Back-to-back req0 with rsp0_ready tied high -> accepts every 3rd cycle; busy low exactly one cycle between operations.
